// File: rtl/uart_rx_fifo.sv
// Receive-character FIFO behind the UART RX shift register: first-word-fall-through read side, fill level, sticky overrun.
// Optional `UART_RX_FIFO_THRESHOLD_EN adds rx_threshold input and registered threshold_hit output.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_ready,
  input  logic                      flush,
  input  logic                      overrun_clear,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty,
  output logic                      overrun
`ifdef UART_RX_FIFO_THRESHOLD_EN
  ,
  input  logic [$clog2(DEPTH):0]    rx_threshold,
  output logic                      threshold_hit
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  overrun_q, overrun_d;
  logic                  push, pop, drop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overrun  = overrun_q;

  assign pop  = rd_valid && rd_ready;
  assign push = wr_valid && (!full || pop);
  assign drop = wr_valid && full && !pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A drop in the same cycle as a clear leaves the flag set.
    if (overrun_clear) overrun_d = 1'b0;
    if (drop && !flush) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

`ifdef UART_RX_FIFO_THRESHOLD_EN
  logic threshold_hit_q, threshold_hit_d;

  assign threshold_hit_d = (rx_threshold != '0) && (level >= rx_threshold);
  assign threshold_hit   = threshold_hit_q;

  always_ff @(posedge clk) begin
    if (rst) threshold_hit_q <= 1'b0;
    else     threshold_hit_q <= threshold_hit_d;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected characters queued at issue, checked by a read-side monitor.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, rd_ready, flush, overrun_clear;
  logic [8:0] wr_data;
  logic       rd_valid, full, empty, overrun;
  logic [8:0] rd_data;
  logic [4:0] level;
`ifdef UART_RX_FIFO_THRESHOLD_EN
  logic [4:0] rx_threshold;
  logic       threshold_hit;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WIDTH(9), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_ready(rd_ready), .flush(flush), .overrun_clear(overrun_clear),
    .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .full(full), .empty(empty), .overrun(overrun)
`ifdef UART_RX_FIFO_THRESHOLD_EN
    , .rx_threshold(rx_threshold), .threshold_hit(threshold_hit)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read-side monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && !flush && rd_valid && rd_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: got %0h expected nothing", rd_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL read_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  task automatic cyc(input logic wv, input logic [8:0] wd, input logic rr,
                     input logic fl, input logic oc);
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl; overrun_clear = oc;
    @(posedge clk); #1;
    wr_valid = 0; wr_data = '0; rd_ready = 0; flush = 0; overrun_clear = 0;
  endtask

  task automatic push(input logic [8:0] d, input logic accepted);
    if (accepted) exp_q.push_back(d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 9'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"},  rd_data,  0);
    chk({tag, "_level"},    level,    0);
    chk({tag, "_empty"},    empty,    1);
    chk({tag, "_full"},     full,     0);
    chk({tag, "_overrun"},  overrun,  0);
  endtask

  initial begin
    rst = 1; wr_valid = 0; wr_data = '0; rd_ready = 0; flush = 0; overrun_clear = 0;
`ifdef UART_RX_FIFO_THRESHOLD_EN
    rx_threshold = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_reset_state("reset");

    // Two pushes, first-word-fall-through.
    push(9'h0A5, 1);
    chk("t1_rd_valid", rd_valid, 1);
    chk("t1_rd_data", rd_data, 9'h0A5);
    chk("t1_level1", level, 1);
    push(9'h15A, 1);
    chk("t1_level2", level, 2);
    pop(); pop();
    chk("t1_empty", empty, 1);
    chk("t1_rd_data_empty", rd_data, 0);

    // Fill, drop, drain; overrun stays sticky.
    for (int i = 0; i < 16; i++) push(9'(i), 1);
    chk("t2_full", full, 1);
    chk("t2_level16", level, 16);
    chk("t2_overrun_before", overrun, 0);
    push(9'h1AB, 0);
    chk("t2_overrun_set", overrun, 1);
    chk("t2_level_after_drop", level, 16);
    for (int i = 0; i < 16; i++) pop();
    chk("t2_empty_after_drain", empty, 1);
    chk("t2_overrun_sticky", overrun, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t2_overrun_cleared", overrun, 0);

    // Push while full with simultaneous pop.
    for (int i = 0; i < 16; i++) push(9'h100 + 9'(i), 1);
    exp_q.push_back(9'h1FF);
    cyc(1, 9'h1FF, 1, 0, 0);
    chk("t3_level_stays16", level, 16);
    chk("t3_no_overrun", overrun, 0);
    // Drop and clear in the same cycle: set wins.
    cyc(1, 9'h0EE, 0, 0, 1);
    chk("t3_set_wins", overrun, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t3_cleared", overrun, 0);
    for (int i = 0; i < 16; i++) pop();
    chk("t3_drained", level, 0);

    // Push/pop pairs across pointer wrap.
    push(9'h040, 1);
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(9'h041 + 9'(i));
      cyc(1, 9'h041 + 9'(i), 1, 0, 0);
      chk("t4_level", level, 1);
    end
    pop();
    chk("t4_empty", empty, 1);

    // Flush with concurrent push.
    for (int i = 0; i < 5; i++) push(9'h0C0 + 9'(i), 1);
    chk("t5_level5", level, 5);
    cyc(1, 9'h0DD, 0, 1, 0);
    exp_q.delete();
    chk("t5_flush_level", level, 0);
    chk("t5_flush_rd_valid", rd_valid, 0);
    chk("t5_flush_overrun", overrun, 0);
    push(9'h0D1, 1);
    chk("t5_post_flush_data", rd_data, 9'h0D1);
    pop();

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) push(9'h033 + 9'(i), 1);
    chk("t6_level3", level, 3);
    rst = 1;
    cyc(1, 9'h077, 1, 1, 0);
    rst = 0;
    exp_q.delete();
    chk_reset_state("t6_rst");

`ifdef UART_RX_FIFO_THRESHOLD_EN
    rx_threshold = 5'd4;
    for (int i = 0; i < 4; i++) push(9'h050 + 9'(i), 1);
    chk("th_lag", threshold_hit, 0);
    cyc(0, 0, 0, 0, 0);
    chk("th_hit", threshold_hit, 1);
    pop();
    cyc(0, 0, 0, 0, 0);
    chk("th_release", threshold_hit, 0);
    rx_threshold = 5'd0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("th_zero", threshold_hit, 0);
    for (int i = 0; i < 3; i++) pop();
`endif

    cyc(0, 0, 0, 0, 0);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_empty", empty, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-data buffer sitting directly downstream of the UART RX shift register. Captures each completed character (the one-cycle `data_valid` pulse and its `rx_data` word) into a circular buffer. Presents characters to the host/bus side through a first-word-fall-through valid/ready interface. Tracks fill level and flags overrun when a character arrives while the buffer is full.

## Interface
- `DATA_WIDTH`, 9: character width; matches the shift register's maximum data bits.
- `DEPTH`, 16: number of entries; must be a power of two, minimum 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `wr_valid`  input  1  one-cycle character-complete pulse from the shift register.
- `wr_data`  input  DATA_WIDTH  received character; sampled only when `wr_valid`=1.
- `rd_ready`  input  1  consumer accepts the head entry this cycle.
- `flush`  input  1  synchronous discard of all stored entries.
- `overrun_clear`  input  1  clears the sticky `overrun` flag.
- `rd_valid`  output  1  head entry is present.
- `rd_data`  output  DATA_WIDTH  head entry; forced to 0 when empty.
- `level`  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- `full`  output  1  `level`==DEPTH.
- `empty`  output  1  `level`==0.
- `overrun`  output  1  sticky: a character was dropped.

## Operation
- Storage is a DEPTH-entry array with write and read pointers of width $clog2(DEPTH)+1.
  - The MSB is the wrap bit; the low bits index the array.
  - Empty when the pointers are equal; full when the low bits are equal and the wrap bits differ.
- Push: `wr_valid`=1 and (not `full` or pop this cycle). Writes `wr_data` at the write pointer, then increments it.
- Pop: `rd_valid`=1 and `rd_ready`=1. Increments the read pointer.
- Push and pop in the same cycle: `level` is unchanged.
  - When full, a simultaneous pop frees the slot, so the push is accepted and `overrun` is not set.
- Drop: `wr_valid`=1, `full`=1, no pop. The character is discarded, pointers are unchanged, and `overrun` is set on the next edge.
- `overrun` holds until `overrun_clear`. If a set and a clear occur in the same cycle, set wins.
- `flush`:
  - Next edge: read pointer loads the write pointer value, `level`=0, `rd_valid`=0.
  - A concurrent push or pop is ignored; flush wins.
  - `overrun` is unaffected.
- Pointers wrap naturally modulo 2·DEPTH; no special handling is needed at index DEPTH-1 → 0.
- `rd_ready` while empty has no effect.

## Timing
- Reset values (registered by `rst` on a clock edge): pointers 0, `level` 0, `overrun` 0, `rd_valid` 0, `rd_data` 0, `empty` 1, `full` 0. Array contents are not reset.
- `rst` mid-operation discards all entries on that edge and takes priority over `flush`, push and pop.
- Write-to-read latency is 1 cycle: a push at edge N gives `rd_valid`=1 and `rd_data`=character after edge N.
- `rd_data` and `rd_valid` are functions of registered state only; there is no combinational path from `wr_*` or `rd_ready`.
- After a pop at edge N, the next entry (or 0 if empty) appears after edge N.
- `level`, `full`, `empty` and `overrun` all update on the same edge as the push, pop or drop that causes them.
- Back-to-back pushes on consecutive cycles are supported.

## Configuration
- Macro `UART_RX_FIFO_THRESHOLD_EN`, when defined, adds:
  - input `rx_threshold` [$clog2(DEPTH):0];
  - registered output `threshold_hit`, which is 1 when `level` ≥ `rx_threshold` and `rx_threshold`≠0; reset value 0.
- `threshold_hit` updates one cycle after `level` or `rx_threshold` changes.
- When the macro is undefined, neither port exists and no threshold logic is built.

## Test plan
- Reset, then push 0x0A5 followed by 0x15A → after the first edge `rd_valid`=1, `rd_data`=0x0A5, `level`=1; after the second, `level`=2. Popping both returns 0x0A5 then 0x15A, then `empty`=1 and `rd_data`=0.
- Fill with DEPTH=16 entries 0..15 → `full`=1, `level`=16. A 17th push with no pop → dropped and `overrun`=1. Draining yields 0..15 in order; `overrun` stays 1 until `overrun_clear`.
- While full, push 0x1FF with a simultaneous pop → `level` stays 16, `overrun` stays 0, and 0x1FF is read last.
- Run 40 push/pop pairs across pointer wrap → data order preserved and `level` never exceeds 16.
- With 5 entries stored, assert `flush` with a concurrent push → `level`=0, `rd_valid`=0, `overrun` unchanged. Assert `rst` with 3 entries stored → every output at its reset value.
- With the macro defined and `rx_threshold`=4: 4 pushes → `threshold_hit`=1 on the following cycle; one pop → returns to 0; `rx_threshold`=0 → stays 0.
